// File: rtl/ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder
//
// Turns the raw PS/2 keyboard clock/data lines into a one-cycle make-code
// strobe for the VGA controller's key-binding logic. Runs entirely in the
// pixel-clock domain.
//
// The PS/2 lines are synchronised and 11-bit frames are deserialised and
// parity-checked. A stalled partial frame is dropped after a timeout. Break
// sequences (F0 xx, E0 F0 xx) and keyboard device responses are swallowed,
// so only key presses reach the consumer. E0-prefixed keys are flagged as
// extended.
//
// Parameters:
//   TIMEOUT_CYCLES - idle clock cycles mid-frame before the partial frame is
//                    discarded (2500 = 100 us at 25 MHz)
//
// Ports:
//   clock     in   pixel clock, all logic on the rising edge
//   reset     in   asynchronous active-high reset, clears all state
//   ps2_clk   in   raw keyboard clock (asynchronous)
//   ps2_data  in   raw keyboard data (asynchronous)
//   key_in    out  last accepted make code, held between strobes
//   key_en    out  one-cycle strobe, key_in/key_ext valid
//   key_ext   out  key_in was prefixed by E0
//   frame_err out  one-cycle pulse on parity/start/stop error or timeout
// ---------------------------------------------------------------------------
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 2500
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_in,
    output logic       key_en,
    output logic       key_ext,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    // -----------------------------------------------------------------------
    // Synchronisers. The clock line gets a third flop so that a falling edge
    // can be detected between two already-synchronised samples. Everything
    // resets high because the idle PS/2 bus is high.
    // -----------------------------------------------------------------------
    logic clk_s1;
    logic clk_s2;
    logic clk_s3;
    logic data_s1;
    logic data_s2;
    logic fall;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            clk_s3  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            clk_s3  <= clk_s2;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
        end
    end

    assign fall = clk_s3 & ~clk_s2;

    // -----------------------------------------------------------------------
    // Frame receiver
    //   bit_cnt 0      : start bit
    //   bit_cnt 1..8   : D0..D7, shifted in from the top so shift ends D7..D0
    //   bit_cnt 9      : odd parity
    //   bit_cnt 10     : stop bit, frame is judged on this fall
    // -----------------------------------------------------------------------
    logic [3:0]    bit_cnt;
    logic [7:0]    shift;
    logic          start_bit;
    logic          parity_bit;
    logic [TW-1:0] timeout_cnt;

    logic timeout_hit;
    logic stop_cycle;
    logic frame_ok;
    logic byte_valid;
    logic err_event;

    // The timeout fires on the edge where the counter would reach
    // TIMEOUT_CYCLES, i.e. after TIMEOUT_CYCLES fall-free cycles mid-frame.
    assign timeout_hit = (bit_cnt != 4'd0) && (timeout_cnt == TIMEOUT_LAST);

    // A fall coinciding with the timeout starts a new frame, so it must not
    // also be judged as the stop bit of the stale one.
    assign stop_cycle = fall && (bit_cnt == 4'd10) && !timeout_hit;
    assign frame_ok   = !start_bit && data_s2 && ((^shift) ^ parity_bit);
    assign byte_valid = stop_cycle && frame_ok;
    assign err_event  = (stop_cycle && !frame_ok) || timeout_hit;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_cnt     <= 4'd0;
            shift       <= 8'h00;
            start_bit   <= 1'b0;
            parity_bit  <= 1'b0;
            timeout_cnt <= '0;
        end else if (fall) begin
            timeout_cnt <= '0;
            if (timeout_hit || bit_cnt == 4'd0) begin
                start_bit <= data_s2;
                bit_cnt   <= 4'd1;
            end else if (bit_cnt == 4'd10) begin
                bit_cnt <= 4'd0;
            end else begin
                if (bit_cnt <= 4'd8) begin
                    shift <= {data_s2, shift[7:1]};
                end else begin
                    parity_bit <= data_s2;
                end
                bit_cnt <= bit_cnt + 4'd1;
            end
        end else if (timeout_hit) begin
            bit_cnt     <= 4'd0;
            timeout_cnt <= '0;
        end else if (bit_cnt != 4'd0) begin
            timeout_cnt <= timeout_cnt + TW'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Sequence FSM: strips break sequences and device responses, tags E0 keys.
    // It acts combinationally on byte_valid so the strobe lands on the edge
    // that ends the stop-bit fall cycle.
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK
    } state_t;

    state_t state;
    state_t state_next;
    logic   emit;
    logic   emit_ext;
    logic   is_response;

    // Self-test pass, ack, echo, resend and error/overrun bytes.
    always_comb begin
        is_response = 1'b0;
        case (shift)
            8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00: is_response = 1'b1;
            default:                           is_response = 1'b0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        emit       = 1'b0;
        emit_ext   = 1'b0;
        if (err_event) begin
            // A corrupted prefix must not mask the next key.
            state_next = IDLE;
        end else if (byte_valid) begin
            case (state)
                IDLE: begin
                    if (shift == 8'hE0) begin
                        state_next = EXT;
                    end else if (shift == 8'hF0) begin
                        state_next = BRK;
                    end else if (!is_response) begin
                        emit = 1'b1;
                    end
                end
                EXT: begin
                    if (shift == 8'hF0) begin
                        state_next = EXT_BRK;
                    end else if (shift != 8'hE0) begin
                        emit       = 1'b1;
                        emit_ext   = 1'b1;
                        state_next = IDLE;
                    end
                end
                BRK:     state_next = IDLE;
                EXT_BRK: state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_in    <= 8'h00;
            key_ext   <= 1'b0;
            key_en    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            key_en    <= emit;
            frame_err <= err_event;
            if (emit) begin
                key_in  <= shift;
                key_ext <= emit_ext;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
module tb_ps2_key_decoder;

    localparam int TIMEOUT = 200;
    localparam int HALF    = 10;   // PS/2 half-bit in clock cycles
    localparam int NVEC    = 20;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] key_in;
    logic       key_en;
    logic       key_ext;
    logic       frame_err;

    ps2_key_decoder #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clock     (clock),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .key_in    (key_in),
        .key_en    (key_en),
        .key_ext   (key_ext),
        .frame_err (frame_err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int en_cnt = 0;
    int err_cnt = 0;
    int overlap_cnt = 0;

    always @(negedge clock) begin
        if (key_en) en_cnt++;
        if (frame_err) err_cnt++;
        if (key_en && frame_err) overlap_cnt++;
    end

    typedef struct {
        logic [7:0] data;
        bit         flip;
        int         exp_en;
        int         exp_err;
        logic [7:0] exp_key;
        bit         exp_ext;
    } vec_t;

    vec_t vecs[NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive bits first..last of a PS/2 frame for byte d (optionally with the
    // parity bit inverted). Lines are changed 1 time unit after a clock edge.
    task automatic send_bits(input logic [7:0] d, input bit flip, input int first, input int last);
        logic [10:0] b;
        b = {1'b1, (~^d) ^ flip, d, 1'b0};
        for (int i = first; i <= last; i++) begin
            ps2_data = b[i];
            repeat (HALF) @(posedge clock);
            #1 ps2_clk = 1'b0;
            repeat (HALF) @(posedge clock);
            #1 ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit flip);
        send_bits(d, flip, 0, 10);
        repeat (40) @(posedge clock);
        #1;
    endtask

    initial begin
        vecs[0]  = '{8'hE0, 1'b0, 0, 0, 8'h6B, 1'b0};
        vecs[1]  = '{8'h74, 1'b0, 1, 0, 8'h74, 1'b1};
        vecs[2]  = '{8'hE0, 1'b0, 0, 0, 8'h74, 1'b1};
        vecs[3]  = '{8'hF0, 1'b0, 0, 0, 8'h74, 1'b1};
        vecs[4]  = '{8'h74, 1'b0, 0, 0, 8'h74, 1'b1};
        vecs[5]  = '{8'h1C, 1'b0, 1, 0, 8'h1C, 1'b0};
        vecs[6]  = '{8'hF0, 1'b0, 0, 0, 8'h1C, 1'b0};
        vecs[7]  = '{8'h1C, 1'b0, 0, 0, 8'h1C, 1'b0};
        vecs[8]  = '{8'h1C, 1'b0, 1, 0, 8'h1C, 1'b0};
        vecs[9]  = '{8'hAA, 1'b0, 0, 0, 8'h1C, 1'b0};
        vecs[10] = '{8'h6B, 1'b1, 0, 1, 8'h1C, 1'b0};
        vecs[11] = '{8'h74, 1'b0, 1, 0, 8'h74, 1'b0};
        vecs[12] = '{8'hE0, 1'b0, 0, 0, 8'h74, 1'b0};
        vecs[13] = '{8'h72, 1'b1, 0, 1, 8'h74, 1'b0};
        vecs[14] = '{8'h72, 1'b0, 1, 0, 8'h72, 1'b0};
        vecs[15] = '{8'hE0, 1'b0, 0, 0, 8'h72, 1'b0};
        vecs[16] = '{8'hE0, 1'b0, 0, 0, 8'h72, 1'b0};
        vecs[17] = '{8'h75, 1'b0, 1, 0, 8'h75, 1'b1};
        vecs[18] = '{8'hFA, 1'b0, 0, 0, 8'h75, 1'b1};
        vecs[19] = '{8'h00, 1'b0, 0, 0, 8'h75, 1'b1};

        // Reset state
        repeat (4) @(posedge clock);
        #1;
        chk("reset_key_in", 32'(key_in), 32'h00);
        chk("reset_key_en", 32'(key_en), 32'h0);
        chk("reset_key_ext", 32'(key_ext), 32'h0);
        chk("reset_frame_err", 32'(frame_err), 32'h0);
        reset = 1'b0;
        repeat (4) @(posedge clock);
        #1;

        // Exact strobe timing for 6B: pin fall -> 3 edges -> key_en
        en_cnt = 0;
        err_cnt = 0;
        send_bits(8'h6B, 1'b0, 0, 9);
        ps2_data = 1'b1;
        repeat (HALF) @(posedge clock);
        #1 ps2_clk = 1'b0;
        @(posedge clock); #1;
        chk("timing_edge1_en", 32'(key_en), 32'h0);
        @(posedge clock); #1;
        chk("timing_edge2_en", 32'(key_en), 32'h0);
        @(posedge clock); #1;
        chk("timing_edge3_en", 32'(key_en), 32'h1);
        chk("timing_edge3_key", 32'(key_in), 32'h6B);
        @(posedge clock); #1;
        chk("timing_edge4_en", 32'(key_en), 32'h0);
        repeat (HALF) @(posedge clock);
        #1 ps2_clk = 1'b1;
        repeat (40) @(posedge clock);
        #1;
        chk("timing_en_count", 32'(en_cnt), 32'd1);
        chk("timing_ext", 32'(key_ext), 32'h0);

        // Table-driven frames
        for (int v = 0; v < NVEC; v++) begin
            en_cnt = 0;
            err_cnt = 0;
            send_frame(vecs[v].data, vecs[v].flip);
            $display("vec %0d: byte %02h flip %0d -> en %0d err %0d key %02h ext %0d",
                     v, vecs[v].data, vecs[v].flip, en_cnt, err_cnt, key_in, key_ext);
            chk($sformatf("vec%0d_en_count", v), 32'(en_cnt), 32'(vecs[v].exp_en));
            chk($sformatf("vec%0d_err_count", v), 32'(err_cnt), 32'(vecs[v].exp_err));
            chk($sformatf("vec%0d_key_in", v), 32'(key_in), 32'(vecs[v].exp_key));
            chk($sformatf("vec%0d_key_ext", v), 32'(key_ext), 32'(vecs[v].exp_ext));
        end

        // Truncated frame: 5 bits then silence until the timeout
        en_cnt = 0;
        err_cnt = 0;
        send_bits(8'h33, 1'b0, 0, 4);
        repeat (TIMEOUT + 50) @(posedge clock);
        #1;
        $display("timeout: en %0d err %0d", en_cnt, err_cnt);
        chk("timeout_err_count", 32'(err_cnt), 32'd1);
        chk("timeout_en_count", 32'(en_cnt), 32'd0);
        en_cnt = 0;
        err_cnt = 0;
        send_frame(8'h75, 1'b0);
        $display("after timeout: en %0d key %02h ext %0d", en_cnt, key_in, key_ext);
        chk("post_timeout_en", 32'(en_cnt), 32'd1);
        chk("post_timeout_err", 32'(err_cnt), 32'd0);
        chk("post_timeout_key", 32'(key_in), 32'h75);

        // Reset during bit 4 of a frame, after an extended key set key_ext
        send_frame(8'hE0, 1'b0);
        send_frame(8'h74, 1'b0);
        chk("pre_reset_ext", 32'(key_ext), 32'h1);
        send_bits(8'h72, 1'b0, 0, 3);
        ps2_data = 1'b0;
        repeat (HALF / 2) @(posedge clock);
        #1 reset = 1'b1;
        ps2_data = 1'b1;
        @(posedge clock); #1;
        chk("midreset_key_in", 32'(key_in), 32'h00);
        chk("midreset_key_en", 32'(key_en), 32'h0);
        chk("midreset_key_ext", 32'(key_ext), 32'h0);
        chk("midreset_frame_err", 32'(frame_err), 32'h0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        repeat (50) @(posedge clock);
        #1;
        en_cnt = 0;
        err_cnt = 0;
        send_frame(8'h72, 1'b0);
        $display("after reset: en %0d err %0d key %02h ext %0d", en_cnt, err_cnt, key_in, key_ext);
        chk("post_reset_en", 32'(en_cnt), 32'd1);
        chk("post_reset_err", 32'(err_cnt), 32'd0);
        chk("post_reset_key", 32'(key_in), 32'h72);
        chk("post_reset_ext", 32'(key_ext), 32'h0);

        chk("en_err_overlap", 32'(overlap_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
